tdc_avg: RTL and testbench
==========================

TDC_AVG -- requirements
Module: tdc_avg

Interface
REQ-001 Parameter W, default 12, width of time code (matches time_counter o_time).
REQ-002 Parameter N_LOG2, default 4, log2 of samples per averaging window (legal 1..8).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_time  input  W  time code from time_counter o_time.
REQ-006 i_wrena  input  1  one-cycle strobe, i_time valid, from time_counter wrena.
REQ-007 i_clear  input  1  abort current window, discard partial sum.
REQ-008 o_avg  output  W  mean of last completed window, held until next window completes.
REQ-009 o_valid  output  1  one-cycle pulse, o_avg updated this cycle.
REQ-010 o_count  output  N_LOG2  samples accepted in current window.
REQ-011 o_drop  output  8  saturating count of rejected zero-code samples.
REQ-012 o_min, o_max  output  W each  window min/max, present only with TDC_AVG_MINMAX_EN.

Function
REQ-013 Sample accepted when i_wrena=1, i_clear=0 and i_time!=0.
REQ-014 i_wrena=1 with i_time=0 (no edge captured) is rejected; o_drop increments, saturating at 255 with no wrap.
REQ-015 FSM states IDLE (count=0, sum=0) and ACCUM (1..2^N_LOG2-1 samples held).
REQ-016 IDLE->ACCUM on accepted sample; ACCUM->IDLE on accepting the 2^N_LOG2-th sample or on i_clear.
REQ-017 Accumulator width W+N_LOG2; no overflow possible for any input sequence.
REQ-018 On 2^N_LOG2-th accepted sample at edge k: o_avg = floor((sum+i_time) >> N_LOG2) visible after edge k, o_valid=1 for exactly that cycle.
REQ-019 Latency: last sample strobe to o_valid is 1 cycle; o_valid never high two consecutive cycles unless N_LOG2 windows complete on consecutive strobes (impossible for N_LOG2>=1).
REQ-020 Accumulator and count clear at the same edge the window completes; a sample on the next cycle starts the new window with no loss.
REQ-021 o_count wraps from 2^N_LOG2-1 to 0 on window completion.
REQ-022 i_clear=1: sum, count -> 0, state IDLE next edge; o_avg, o_drop unchanged; no o_valid.
REQ-023 i_clear and i_wrena same cycle: clear wins, sample discarded, o_drop not incremented.
REQ-024 Rejected samples do not advance o_count or affect sum.

Reset
REQ-025 rst=1 at a clock edge: state IDLE, sum=0, o_count=0, o_avg=0, o_valid=0, o_drop=0, o_min=all-ones, o_max=0.
REQ-026 rst mid-window discards partial window; rst overrides i_clear and i_wrena.
REQ-027 Outputs valid the first cycle after rst deasserts; first sample accepted on that cycle.

Configuration
REQ-028 Macro TDC_AVG_MINMAX_EN defined: o_min/o_max ports exist, track min/max of accepted samples in current window, latch to outputs with o_valid, internal trackers reinit (all-ones / 0) at window completion, i_clear, rst.
REQ-029 Macro undefined: o_min/o_max ports and tracking logic absent; all other behaviour identical.

Verification
REQ-030 16 strobes i_time=100 (N_LOG2=4) -> o_valid one cycle after 16th strobe, o_avg=100, o_count back to 0.
REQ-031 16 strobes i_time=1..16 -> sum 136, o_avg=8 (floor); with MINMAX_EN o_min=1, o_max=16.
REQ-032 16 strobes i_time=4095 -> o_avg=4095, no overflow; next strobe sets o_count=1.
REQ-033 300 strobes i_time=0 -> o_drop=255 saturated, o_count=0, no o_valid.
REQ-034 5 strobes i_time=10, then i_clear with i_wrena i_time=10 same cycle, then 16 strobes i_time=50 -> single o_valid, o_avg=50.
REQ-035 rst asserted after 8 strobes of 200, then 16 strobes of 30 -> o_avg=30, o_drop=0, only one o_valid.

Source files
------------

// File: rtl/tdc_avg.sv
// Averages time codes over windows of 2**N_LOG2 non-zero samples and counts rejected zero codes.
// Define TDC_AVG_MINMAX_EN to add per-window minimum/maximum outputs (o_min/o_max).
module tdc_avg #(
    parameter int W      = 12,
    parameter int N_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      i_time,
    input  logic              i_wrena,
    input  logic              i_clear,
    output logic [W-1:0]      o_avg,
    output logic              o_valid,
    output logic [N_LOG2-1:0] o_count,
    output logic [7:0]        o_drop
`ifdef TDC_AVG_MINMAX_EN
    ,
    output logic [W-1:0]      o_min,
    output logic [W-1:0]      o_max
`endif
);

    localparam int SW = W + N_LOG2;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t            state_q;
    logic [SW-1:0]     sum_q;
    logic [N_LOG2-1:0] count_q;
    logic [W-1:0]      avg_q;
    logic              valid_q;
    logic [7:0]        drop_q;

    logic              accept;
    logic              reject;
    logic              last;
    logic [SW-1:0]     sum_d;
    logic [W-1:0]      avg_d;

    // A zero code means no edge was captured, so it is counted as a drop, never averaged.
    assign accept = i_wrena && !i_clear && (i_time != '0);
    assign reject = i_wrena && !i_clear && (i_time == '0);
    assign last   = accept && (state_q == ACCUM) && (count_q == '1);
    assign sum_d  = sum_q + SW'(i_time);
    assign avg_d  = W'(sum_d >> N_LOG2);

`ifdef TDC_AVG_MINMAX_EN
    logic [W-1:0] min_q;
    logic [W-1:0] max_q;
    logic [W-1:0] min_d;
    logic [W-1:0] max_d;
    logic [W-1:0] min_out_q;
    logic [W-1:0] max_out_q;

    assign min_d = (i_time < min_q) ? i_time : min_q;
    assign max_d = (i_time > max_q) ? i_time : max_q;
    assign o_min = min_out_q;
    assign o_max = max_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q     <= '1;
            max_q     <= '0;
            min_out_q <= '1;
            max_out_q <= '0;
        end else if (i_clear) begin
            min_q <= '1;
            max_q <= '0;
        end else if (last) begin
            min_out_q <= min_d;
            max_out_q <= max_d;
            min_q     <= '1;
            max_q     <= '0;
        end else if (accept) begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            count_q <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            if (reject && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sum_q   <= sum_d;
                        count_q <= count_q + 1'b1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (i_clear) begin
                        sum_q   <= '0;
                        count_q <= '0;
                        state_q <= IDLE;
                    end else if (last) begin
                        // Window closes: publish the mean and restart so the next strobe is not lost.
                        avg_q   <= avg_d;
                        valid_q <= 1'b1;
                        sum_q   <= '0;
                        count_q <= '0;
                        state_q <= IDLE;
                    end else if (accept) begin
                        sum_q   <= sum_d;
                        count_q <= count_q + 1'b1;
                    end
                end
                default: begin
                    sum_q   <= '0;
                    count_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_avg   = avg_q;
    assign o_valid = valid_q;
    assign o_count = count_q;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_tdc_avg.sv
// Randomised and directed bench for tdc_avg; window results are predicted from a list of accepted samples.
module tb_tdc_avg;

    localparam int W      = 12;
    localparam int N_LOG2 = 4;
    localparam int WIN    = 1 << N_LOG2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [W-1:0]      i_time = '0;
    logic              i_wrena = 1'b0;
    logic              i_clear = 1'b0;
    logic [W-1:0]      o_avg;
    logic              o_valid;
    logic [N_LOG2-1:0] o_count;
    logic [7:0]        o_drop;
`ifdef TDC_AVG_MINMAX_EN
    logic [W-1:0]      o_min;
    logic [W-1:0]      o_max;
`endif

    tdc_avg #(.W(W), .N_LOG2(N_LOG2)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_time  (i_time),
        .i_wrena (i_wrena),
        .i_clear (i_clear),
        .o_avg   (o_avg),
        .o_valid (o_valid),
        .o_count (o_count),
        .o_drop  (o_drop)
`ifdef TDC_AVG_MINMAX_EN
        ,
        .o_min   (o_min),
        .o_max   (o_max)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    int           n_cmp = 0;
    int           n_fail = 0;
    bit           started = 0;
    int           win[$];
    int           m_drop = 0;
    int           m_avg = 0;
    int           m_min = (1 << W) - 1;
    int           m_max = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_min_q[$];
    logic [W-1:0] exp_max_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic w, input logic [W-1:0] t, input logic c);
        int s;
        int mn;
        int mx;
        if (r) begin
            win.delete();
            m_drop  = 0;
            m_avg   = 0;
            m_min   = (1 << W) - 1;
            m_max   = 0;
            started = 1;
        end else if (c) begin
            win.delete();
        end else if (w) begin
            if (t == 0) begin
                if (m_drop < 255) m_drop++;
            end else begin
                win.push_back(int'(t));
                if (win.size() == WIN) begin
                    s  = 0;
                    mn = (1 << W) - 1;
                    mx = 0;
                    foreach (win[i]) begin
                        s += win[i];
                        if (win[i] < mn) mn = win[i];
                        if (win[i] > mx) mx = win[i];
                    end
                    m_avg = s / WIN;
                    m_min = mn;
                    m_max = mx;
                    exp_q.push_back(W'(m_avg));
                    exp_min_q.push_back(W'(mn));
                    exp_max_q.push_back(W'(mx));
                    win.delete();
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [W-1:0] t, input logic c);
        rst     = r;
        i_wrena = w;
        i_time  = t;
        i_clear = c;
        @(posedge clk);
        model_update(r, w, t, c);
        #1;
    endtask

    task automatic strobes(input int n, input int t);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, W'(t), 1'b0);
    endtask

    function automatic logic [W-1:0] rand_t();
        if ($urandom_range(0, 7) == 0) return '0;
        return W'($urandom_range(1, (1 << W) - 1));
    endfunction

    // Monitor: compares DUT outputs with the model on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            check("o_count", 32'(o_count), 32'(win.size()));
            check("o_drop", 32'(o_drop), 32'(m_drop));
            check("o_avg_held", 32'(o_avg), 32'(m_avg));
`ifdef TDC_AVG_MINMAX_EN
            check("o_min_held", 32'(o_min), 32'(m_min));
            check("o_max_held", 32'(o_max), 32'(m_max));
`endif
            if (o_valid !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(o_valid), 32'd0);
                end else begin
                    check("avg_on_valid", 32'(o_avg), 32'(exp_q.pop_front()));
`ifdef TDC_AVG_MINMAX_EN
                    check("min_on_valid", 32'(o_min), 32'(exp_min_q.pop_front()));
                    check("max_on_valid", 32'(o_max), 32'(exp_max_q.pop_front()));
`else
                    void'(exp_min_q.pop_front());
                    void'(exp_max_q.pop_front());
`endif
                end
            end else if (exp_q.size() != 0) begin
                check("missing_valid", 32'(o_valid), 32'd1);
                void'(exp_q.pop_front());
                void'(exp_min_q.pop_front());
                void'(exp_max_q.pop_front());
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, W'(7), 1'b1);
        // Constant window
        strobes(WIN, 100);
        step(1'b0, 1'b0, '0, 1'b0);
        // Ramp 1..16, floor of 136/16
        for (int i = 1; i <= WIN; i++) step(1'b0, 1'b1, W'(i), 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        // Full-scale codes, then a strobe right after completion
        strobes(WIN, (1 << W) - 1);
        strobes(1, 9);
        step(1'b1, 1'b0, '0, 1'b0);
        // Drop counter saturation
        strobes(300, 0);
        step(1'b1, 1'b0, '0, 1'b0);
        // Clear collides with a strobe
        strobes(5, 10);
        step(1'b0, 1'b1, W'(10), 1'b1);
        strobes(WIN, 50);
        step(1'b0, 1'b0, '0, 1'b0);
        // Reset mid-window
        strobes(8, 200);
        step(1'b1, 1'b1, W'(200), 1'b0);
        strobes(WIN, 30);
        step(1'b0, 1'b0, '0, 1'b0);
        // Clear without strobe, and idle strobe-less codes
        strobes(3, 77);
        step(1'b0, 1'b0, W'(99), 1'b1);
        step(1'b0, 1'b0, W'(99), 1'b0);
        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 1)       step(1'b1, 1'($urandom_range(0, 1)), rand_t(), 1'b0);
            else if (r < 4)  step(1'b0, 1'($urandom_range(0, 1)), rand_t(), 1'b1);
            else if (r < 70) step(1'b0, 1'b1, rand_t(), 1'b0);
            else             step(1'b0, 1'b0, rand_t(), 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
